// File: rtl/conv_mac_sched_if.sv
// Handshake and memory-address bundle between conv_mac_sched and its datapath.
interface conv_mac_sched_if #(
  parameter int X_MEM_ADDR_WIDTH = 7,
  parameter int F_MEM_ADDR_WIDTH = 5
);
  logic                        conv_start;
  logic                        m_ready_y;
  logic [X_MEM_ADDR_WIDTH-1:0] xmem_rd_addr;
  logic [F_MEM_ADDR_WIDTH-1:0] fmem_rd_addr;
  logic                        acc_clr;
  logic                        acc_en;
  logic                        y_load;
  logic                        m_valid_y;
  logic                        conv_done;
  logic                        busy;

  modport master (
    input  conv_start,
    input  m_ready_y,
    output xmem_rd_addr,
    output fmem_rd_addr,
    output acc_clr,
    output acc_en,
    output y_load,
    output m_valid_y,
    output conv_done,
    output busy
  );

  modport slave (
    output conv_start,
    output m_ready_y,
    input  xmem_rd_addr,
    input  fmem_rd_addr,
    input  acc_clr,
    input  acc_en,
    input  y_load,
    input  m_valid_y,
    input  conv_done,
    input  busy
  );
endinterface

// File: rtl/conv_mac_sched.sv
// MAC sequencing controller for a time-multiplexed valid convolution.
// Define CONV_OVERLAP_EN to overlap the next window with the pending y.
module conv_mac_sched #(
  parameter int X_SIZE           = 128,
  parameter int F_SIZE           = 32,
  parameter int X_MEM_ADDR_WIDTH = $clog2(X_SIZE),
  parameter int F_MEM_ADDR_WIDTH = $clog2(F_SIZE),
  parameter int PIPE_DEPTH       = 1
) (
  input logic              clk,
  input logic              reset,
  conv_mac_sched_if.master bus
);

  localparam int XW = X_MEM_ADDR_WIDTH;
  localparam int FW = F_MEM_ADDR_WIDTH;
  localparam logic [XW-1:0] K_LAST = XW'(X_SIZE - F_SIZE);
  localparam logic [FW-1:0] T_LAST = FW'(F_SIZE - 1);
  localparam logic [1:0]    D_LAST = 2'(PIPE_DEPTH);

`ifdef CONV_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MAC   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [XW-1:0] k;
  logic [FW-1:0] t;
  logic [1:0]    d;
  logic          arm;
  logic          valid;
  logic [XW-1:0] x_hold;
  logic [FW-1:0] f_hold;
  logic          issue;
  logic          first;
  logic          drain_last;
  logic          stall;
  logic          load;
  logic          hs;
  logic          tok_en;
  logic          tok_clr;

  assign issue      = (state == MAC);
  assign first      = (t == '0);
  assign drain_last = (state == DRAIN) && (d == D_LAST);
  assign hs         = valid && bus.m_ready_y;

  // y register acts as a one-entry buffer: wait until it frees up
  assign stall = OVERLAP && drain_last && valid && !bus.m_ready_y;
  assign load  = drain_last && !stall;

  generate
    if (PIPE_DEPTH == 0) begin : g_nopipe
      assign tok_en  = issue;
      assign tok_clr = issue && first;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] en_q;
      logic [PIPE_DEPTH-1:0] clr_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          en_q  <= '0;
          clr_q <= '0;
        end else if (!stall) begin
          en_q  <= (en_q << 1) | PIPE_DEPTH'(issue);
          clr_q <= (clr_q << 1) | PIPE_DEPTH'(issue && first);
        end
      end

      assign tok_en  = en_q[PIPE_DEPTH-1];
      assign tok_clr = clr_q[PIPE_DEPTH-1];
    end
  endgenerate

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.conv_start && arm) state_nx = MAC;
      MAC:     if (t == T_LAST) state_nx = DRAIN;
      DRAIN: begin
        if (load)
          state_nx = (OVERLAP && k != K_LAST) ? MAC : HOLD;
      end
      HOLD:    if (hs) state_nx = (k == K_LAST) ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      t      <= '0;
      d      <= '0;
      arm    <= 1'b0;
      valid  <= 1'b0;
      x_hold <= '0;
      f_hold <= '0;
    end else begin
      state <= state_nx;
      if (state == DONE)
        arm <= 1'b0;
      else if (!bus.conv_start)
        arm <= 1'b1;
      unique case (state)
        IDLE: begin
          if (state_nx == MAC) begin
            k <= '0;
            t <= '0;
          end
        end
        MAC: begin
          x_hold <= k + XW'(t);
          f_hold <= t;
          t      <= (t == T_LAST) ? '0 : t + 1'b1;
          d      <= '0;
        end
        DRAIN: begin
          if (!drain_last)
            d <= d + 1'b1;
          else if (load && state_nx == MAC)
            k <= k + 1'b1;
        end
        HOLD: begin
          if (hs && k != K_LAST)
            k <= k + 1'b1;
        end
        default: ;
      endcase
      if (load)
        valid <= 1'b1;
      else if (hs)
        valid <= 1'b0;
    end
  end

  assign bus.xmem_rd_addr = issue ? k + XW'(t) : x_hold;
  assign bus.fmem_rd_addr = issue ? t : f_hold;
  assign bus.acc_en       = tok_en && !stall;
  assign bus.acc_clr      = tok_clr && bus.acc_en;
  assign bus.y_load       = load;
  assign bus.m_valid_y    = valid;
  assign bus.conv_done    = (state == DONE);
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_conv_mac_sched.sv
// Directed bench for conv_mac_sched: window timing, full frame,
// output stall, retrigger guard and mid-frame reset.
module tb_conv_mac_sched;
  localparam int XW = 7;
  localparam int FW = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt, yl_cnt, done_cnt, done_cyc;
  int   ex, ef, een, eclr, eyl, emv;

  conv_mac_sched_if #(
    .X_MEM_ADDR_WIDTH(XW),
    .F_MEM_ADDR_WIDTH(FW)
  ) bus ();

  conv_mac_sched #(
    .X_SIZE(128),
    .F_SIZE(32),
    .X_MEM_ADDR_WIDTH(XW),
    .F_MEM_ADDR_WIDTH(FW),
    .PIPE_DEPTH(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_en"}, int'(bus.acc_en), 0);
    check({tag, "_clr"}, int'(bus.acc_clr), 0);
    check({tag, "_yl"}, int'(bus.y_load), 0);
    check({tag, "_mv"}, int'(bus.m_valid_y), 0);
    check({tag, "_done"}, int'(bus.conv_done), 0);
    check({tag, "_x"}, int'(bus.xmem_rd_addr), 0);
    check({tag, "_f"}, int'(bus.fmem_rd_addr), 0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.conv_start = 1'b0;
    bus.m_ready_y  = 1'b1;
    repeat (3) tick();
    check_idle_outs("rst");
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    // frame 1: cycle 0 is the current cycle
    tick();
    bus.conv_start = 1'b1;
    hs_cnt   = 0;
    yl_cnt   = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 3412; cyc++) begin
      tick();
      bus.m_ready_y = !(cyc >= 210 && cyc <= 219);
      @(negedge clk);
      if (bus.m_valid_y && bus.m_ready_y) hs_cnt++;
      if (bus.y_load) yl_cnt++;
      if (bus.conv_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc <= 37) begin
        if (cyc <= 32) begin
          ex = cyc - 1;
          ef = cyc - 1;
        end else if (cyc <= 35) begin
          ex = 31;
          ef = 31;
        end else begin
          ex = cyc - 35;
          ef = cyc - 36;
        end
        een  = ((cyc >= 2 && cyc <= 33) || cyc == 37) ? 1 : 0;
        eclr = (cyc == 2 || cyc == 37) ? 1 : 0;
        eyl  = (cyc == 34) ? 1 : 0;
        emv  = (cyc == 35) ? 1 : 0;
        check($sformatf("w0_x@%0d", cyc), int'(bus.xmem_rd_addr), ex);
        check($sformatf("w0_f@%0d", cyc), int'(bus.fmem_rd_addr), ef);
        check($sformatf("w0_en@%0d", cyc), int'(bus.acc_en), een);
        check($sformatf("w0_clr@%0d", cyc), int'(bus.acc_clr), eclr);
        check($sformatf("w0_yl@%0d", cyc), int'(bus.y_load), eyl);
        check($sformatf("w0_mv@%0d", cyc), int'(bus.m_valid_y), emv);
        check($sformatf("w0_busy@%0d", cyc), int'(bus.busy), 1);
      end
      if (cyc >= 210 && cyc <= 219) begin
        check($sformatf("stall_mv@%0d", cyc), int'(bus.m_valid_y), 1);
        check($sformatf("stall_x@%0d", cyc), int'(bus.xmem_rd_addr), 36);
        check($sformatf("stall_f@%0d", cyc), int'(bus.fmem_rd_addr), 31);
      end
      if (cyc == 221) begin
        check("k6_x", int'(bus.xmem_rd_addr), 6);
        check("k6_f", int'(bus.fmem_rd_addr), 0);
        check("k6_mv", int'(bus.m_valid_y), 0);
      end
      if (cyc == 3371) check("k96_x0", int'(bus.xmem_rd_addr), 96);
      if (cyc == 3402) begin
        check("k96_xl", int'(bus.xmem_rd_addr), 127);
        check("k96_fl", int'(bus.fmem_rd_addr), 31);
      end
      if (cyc == 3406) check("done_busy", int'(bus.busy), 1);
      if (cyc >= 3407)
        check($sformatf("post_busy@%0d", cyc), int'(bus.busy), 0);
    end
    check("hs_cnt", hs_cnt, 97);
    check("yl_cnt", yl_cnt, 97);
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_cyc, 3406);

    // low-then-high conv_start re-arms; frame 2 starts at k=0
    tick();
    bus.conv_start = 1'b0;
    tick();
    @(negedge clk);
    check("rearm_busy", int'(bus.busy), 0);
    tick();
    bus.conv_start = 1'b1;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 499; cyc++) begin
      tick();
      @(negedge clk);
      if (bus.conv_done) done_cnt++;
      if (cyc == 1) begin
        check("f2_x", int'(bus.xmem_rd_addr), 0);
        check("f2_f", int'(bus.fmem_rd_addr), 0);
        check("f2_busy", int'(bus.busy), 1);
      end
      if (cyc == 2) check("f2_clr", int'(bus.acc_clr), 1);
    end
    tick();
    check("pre_rst_x", int'(bus.xmem_rd_addr), 23);
    check("pre_rst_f", int'(bus.fmem_rd_addr), 9);
    reset = 1'b0;
    #1;
    check_idle_outs("arst");
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (bus.conv_done) done_cnt++;
      check($sformatf("noarm_busy%0d", i), int'(bus.busy), 0);
    end
    check("f2_done_cnt", done_cnt, 0);
    tick();
    bus.conv_start = 1'b0;
    tick();
    bus.conv_start = 1'b1;
    tick();
    @(negedge clk);
    check("f3_busy", int'(bus.busy), 1);
    check("f3_x", int'(bus.xmem_rd_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
